// File: rtl/imem_dual_port_if.sv
// Fetch/load bus of the dual-port instruction memory: two read slots plus a
// valid/ready program-load write port.
interface imem_dual_port_if #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               imem_ren;
    logic [PC_W-1:0]    imem_addr0;
    logic [PC_W-1:0]    imem_addr1;
    logic [INSTR_W-1:0] imem_rdata0;
    logic [INSTR_W-1:0] imem_rdata1;
    logic [1:0]         imem_err;
    logic               imem_ready;
    logic               ld_valid;
    logic               ld_ready;
    logic [PC_W-1:0]    ld_addr;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_err;

    modport master (
        output imem_ren, imem_addr0, imem_addr1, ld_valid, ld_addr, ld_data,
        input  imem_rdata0, imem_rdata1, imem_err, imem_ready, ld_ready, ld_err
    );

    modport slave (
        input  imem_ren, imem_addr0, imem_addr1, ld_valid, ld_addr, ld_data,
        output imem_rdata0, imem_rdata1, imem_err, imem_ready, ld_ready, ld_err
    );
endinterface

// File: rtl/imem_dual_port.sv
// Dual-read-port instruction memory with NOP clear sequencer and load port.
// Define IMEM_WR_FWD_EN for write-first forwarding of same-edge loads to reads.
module imem_dual_port #(
    parameter int unsigned       PC_W     = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 16,
    parameter logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013
) (
    input logic              clk_i,
    input logic              rst_ni,
    imem_dual_port_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] idx_t;
    typedef enum logic [0:0] {StClear, StRun} state_e;

    function automatic logic addr_bad(input logic [PC_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != '0);
    endfunction

    function automatic idx_t addr_idx(input logic [PC_W-1:0] a);
        return a[AW+1:2];
    endfunction

    state_e                      state_q;
    idx_t                        clr_idx_q;
    logic                        ready_q;
    logic [1:0][INSTR_W-1:0]     rdata_q;
    logic [1:0][INSTR_W-1:0]     rdata_d;
    logic [1:0]                  err_q;
    logic [1:0]                  err_d;
    logic                        ld_err_q;
    logic [INSTR_W-1:0]          mem_q [DEPTH];

    logic [1:0][PC_W-1:0]        rd_addr;
    logic                        ld_fire;
    logic                        ld_bad;
    idx_t                        ld_idx;
    logic                        ld_wr;
    logic                        mem_we;
    idx_t                        mem_widx;
    logic [INSTR_W-1:0]          mem_wdata;

    assign rd_addr[0] = bus.imem_addr0;
    assign rd_addr[1] = bus.imem_addr1;
    assign ld_fire    = bus.ld_valid && ready_q;
    assign ld_bad     = addr_bad(bus.ld_addr);
    assign ld_idx     = addr_idx(bus.ld_addr);
    assign ld_wr      = ld_fire && !ld_bad;

    always_comb begin
        rdata_d = '0;
        err_d   = '0;
        for (int s = 0; s < 2; s++) begin
            rdata_d[s] = mem_q[addr_idx(rd_addr[s])];
`ifdef IMEM_WR_FWD_EN
            if (ld_wr && (addr_idx(rd_addr[s]) == ld_idx)) begin
                rdata_d[s] = bus.ld_data;
            end
`endif
            err_d[s] = addr_bad(rd_addr[s]);
            if (err_d[s]) begin
                rdata_d[s] = NOP_WORD;
            end
        end
    end

    // The clear sequencer owns the write port until RUN; loads are not accepted before then.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = ld_idx;
        mem_wdata = bus.ld_data;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_widx  = clr_idx_q;
            mem_wdata = NOP_WORD;
        end else if (ld_wr) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= '0;
            ld_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_idx_q <= clr_idx_q + idx_t'(1);
                    if (clr_idx_q == idx_t'(DEPTH - 1)) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (bus.imem_ren) begin
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                    end
                    if (ld_fire && ld_bad) begin
                        ld_err_q <= 1'b1;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    assign bus.imem_rdata0 = rdata_q[0];
    assign bus.imem_rdata1 = rdata_q[1];
    assign bus.imem_err    = err_q;
    assign bus.imem_ready  = ready_q;
    assign bus.ld_ready    = ready_q;
    assign bus.ld_err      = ld_err_q;
endmodule

// File: doc/imem_dual_port.md
# imem_dual_port

Dual-read-port synchronous instruction memory that answers the fetch unit's two-slot `imem_ren`/`imem_addr0`/`imem_addr1` requests with registered `imem_rdata0`/`imem_rdata1` one cycle later. It is the responder end of the fetch–imem interface. It also has a valid/ready program-load write port and a post-reset clear sequencer that fills every word with NOP before fetch is allowed. It sits between the fetch stage and the program loader (bench or boot logic).

## Interface
- `PC_W`, 32, address width (byte address).
- `INSTR_W`, 32, instruction width.
- `DEPTH`, 16, number of words; power of two, ≥ 4. `AW = $clog2(DEPTH)`.
- `NOP_WORD`, 32'h00000013, clear/fill value.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_ren`  in  1  read enable for both slots.
- `imem_addr0`  in  PC_W  slot 0 byte address.
- `imem_addr1`  in  PC_W  slot 1 byte address.
- `imem_rdata0`  out  INSTR_W  slot 0 read data (registered).
- `imem_rdata1`  out  INSTR_W  slot 1 read data (registered).
- `imem_err`  out  2  per-slot bad-address flag, registered with data.
- `imem_ready`  out  1  high once the clear sequence has completed.
- `ld_valid`  in  1  load write request.
- `ld_ready`  out  1  load port can accept.
- `ld_addr`  in  PC_W  load byte address.
- `ld_data`  in  INSTR_W  load word.
- `ld_err`  out  1  sticky flag: a load with a bad address was dropped.

## Operation
- FSM states: CLEAR and RUN. Reset forces CLEAR with `clr_idx` = 0.
- CLEAR: each cycle writes `NOP_WORD` to `mem[clr_idx]` and increments `clr_idx`. After the write to index DEPTH-1, move to RUN.
  - `imem_ready` = 0 and `ld_ready` = 0.
  - Reads are ignored; outputs hold their values.
- RUN: `imem_ready` = 1 and `ld_ready` = 1. There is no exit except reset.
- Word index for every address is `addr[AW+1:2]`.
- An address is bad if `addr[1:0]` ≠ 0 or `addr[PC_W-1:AW+2]` ≠ 0.
- Read, in RUN with `imem_ren` = 1, for each slot i:
  - Good address: `imem_rdata_i` ← `mem[idx_i]` and `imem_err[i]` ← 0.
  - Bad address: `imem_rdata_i` ← `NOP_WORD` and `imem_err[i]` ← 1.
  - Both slots are independent; identical addresses are legal and return the same word.
- `imem_ren` = 0: rdata and err hold their previous values. This matches the fetch unit's stall behaviour.
- Load: a write occurs when `ld_valid && ld_ready`.
  - Good address: `mem[idx]` ← `ld_data`.
  - Bad address: the write is dropped and `ld_err` ← 1. `ld_err` is sticky until reset.
- Simultaneous load and read of the same index: see Configuration.

## Timing
- Reset values: `imem_rdata0`/`imem_rdata1` = 0, `imem_err` = 2'b00, `imem_ready` = 0, `ld_ready` = 0, `ld_err` = 0, FSM = CLEAR, `clr_idx` = 0.
- CLEAR lasts exactly DEPTH rising edges after reset deassertion. `imem_ready` is high after edge DEPTH.
- Read latency is 1 cycle. Address and `imem_ren` are sampled at edge N; data and err are valid after edge N and stable until the next enabled read.
- Load latency is 1 cycle. A word written at edge N is visible to a read sampled at edge N+1 (data valid after N+1).
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronously).
  - After deassertion, CLEAR repeats, so all loaded contents are lost.
- Throughput: two reads plus one load per cycle, no bubbles in RUN.

## Configuration
- `IMEM_WR_FWD_EN` defined: when a load and a read of the same index are accepted on the same edge, the read returns `ld_data` (write-first forwarding), per slot.
- `IMEM_WR_FWD_EN` undefined: the read returns the old contents (read-first); the new word is visible from the next read onward.
- All other behaviour is identical in both builds.

## Test plan
- Reset release, DEPTH = 16, `imem_ren` = 1 with addr0 = 0x00, addr1 = 0x04 held throughout:
  - `imem_ready` = 0 and rdata = 0 for 16 edges.
  - `imem_ready` = 1 after edge 16.
  - The first enabled read returns 0x00000013 on both slots.
- Load 0x11111111 to 0x00, 0x22222222 to 0x04, …, 0x66666666 to 0x14, then read (0x08, 0x0C):
  - The next cycle gives rdata0 = 0x33333333, rdata1 = 0x44444444, err = 00.
  - Drop `imem_ren` for 2 cycles: the outputs hold those values.
- Read addr0 = 0x02, addr1 = 0x40 → rdata0 = rdata1 = 0x00000013, err = 2'b11.
  - Then load to 0x41 → write dropped, `ld_err` = 1 and it stays 1.
- Same edge: load 0xAAAAAAAA to 0x10 and read addr0 = 0x10:
  - With `IMEM_WR_FWD_EN`, rdata0 = 0xAAAAAAAA.
  - Without it, rdata0 = 0x55555555, and the next read of 0x10 returns 0xAAAAAAAA.
- Assert reset mid-stream after loads:
  - Outputs go to 0 immediately.
  - After deassertion, `imem_ready` is low for 16 edges.
  - The first read of 0x08 then returns 0x00000013.
